uf_edge_scheduler: RTL and testbench

- Sequences a union-find datapath for Kruskal-style connectivity: consumes a pre-sorted stream of (u,v) edges, issues find requests for both endpoints, and issues a link command when the roots differ.
- Tracks the remaining component count, edges consumed, merges and the last merging edge.
- Sits between the edge sorter and the union-find engine; owns every find/link request that reaches the engine.

---
 rtl/uf_edge_scheduler_if.sv | 40 ++++
 rtl/uf_edge_scheduler.sv | 170 +++++++++++++++++
 tb/tb_uf_edge_scheduler.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uf_edge_scheduler_if.sv
// Edge-stream, find and link channels between the edge sorter, the scheduler
// and the union-find engine. master = scheduler side, slave = environment side.
interface uf_edge_scheduler_if #(
   parameter int IW = 11
);
   logic          edge_valid;
   logic          edge_ready;
   logic [IW-1:0] edge_u;
   logic [IW-1:0] edge_v;
   logic          edge_last;

   logic          find_req_valid;
   logic          find_req_ready;
   logic [IW-1:0] find_req_idx;
   logic          find_rsp_valid;
   logic [IW-1:0] find_rsp_root;

   logic          link_valid;
   logic          link_ready;
   logic [IW-1:0] link_child;
   logic [IW-1:0] link_parent;

   modport master (
      input  edge_valid, edge_u, edge_v, edge_last,
      output edge_ready,
      output find_req_valid, find_req_idx,
      input  find_req_ready, find_rsp_valid, find_rsp_root,
      output link_valid, link_child, link_parent,
      input  link_ready
   );

   modport slave (
      output edge_valid, edge_u, edge_v, edge_last,
      input  edge_ready,
      input  find_req_valid, find_req_idx,
      output find_req_ready, find_rsp_valid, find_rsp_root,
      input  link_valid, link_child, link_parent,
      output link_ready
   );
endinterface

// File: rtl/uf_edge_scheduler.sv
// Kruskal-style edge scheduler: one edge in flight, two finds per edge, a link
// when the roots differ; tracks components, edges consumed, merges, last merge.
module uf_edge_scheduler #(
   parameter  int MAX_NODE_COUNT  = 2000,
   parameter  int LIMIT_WIDTH     = 16,
   localparam int INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT),
   localparam int COUNT_WIDTH     = $clog2(MAX_NODE_COUNT + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_i,
   input  logic [COUNT_WIDTH-1:0]     node_count_i,
   input  logic [LIMIT_WIDTH-1:0]     edge_limit_i,
   uf_edge_scheduler_if.master        bus,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       error_o,
   output logic [COUNT_WIDTH-1:0]     components_o,
   output logic [LIMIT_WIDTH-1:0]     edges_consumed_o,
   output logic [COUNT_WIDTH-1:0]     merges_o,
   output logic [INDEX_BIT_WIDTH-1:0] last_u_o,
   output logic [INDEX_BIT_WIDTH-1:0] last_v_o
);
   localparam int IW = INDEX_BIT_WIDTH;
   localparam int CW = COUNT_WIDTH;
   localparam int LW = LIMIT_WIDTH;

   typedef enum logic [3:0] {
      S_IDLE, S_ACCEPT, S_FIND_U, S_WAIT_U, S_FIND_V, S_WAIT_V, S_LINK, S_CHECK, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] nc_q, nc_d, comp_q, comp_d, merges_q, merges_d;
   logic [LW-1:0] lim_q, lim_d, ec_q, ec_d;
   logic [IW-1:0] u_q, u_d, v_q, v_d, ru_q, ru_d, rv_q, rv_d, lu_q, lu_d, lv_q, lv_d;
   logic          last_q, last_d, err_q, err_d;
   logic          ru_lt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         nc_q     <= '0;
         comp_q   <= '0;
         merges_q <= '0;
         lim_q    <= '0;
         ec_q     <= '0;
         u_q      <= '0;
         v_q      <= '0;
         ru_q     <= '0;
         rv_q     <= '0;
         lu_q     <= '0;
         lv_q     <= '0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         nc_q     <= nc_d;
         comp_q   <= comp_d;
         merges_q <= merges_d;
         lim_q    <= lim_d;
         ec_q     <= ec_d;
         u_q      <= u_d;
         v_q      <= v_d;
         ru_q     <= ru_d;
         rv_q     <= rv_d;
         lu_q     <= lu_d;
         lv_q     <= lv_d;
         last_q   <= last_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      nc_d     = nc_q;
      comp_d   = comp_q;
      merges_d = merges_q;
      lim_d    = lim_q;
      ec_d     = ec_q;
      u_d      = u_q;
      v_d      = v_q;
      ru_d     = ru_q;
      rv_d     = rv_q;
      lu_d     = lu_q;
      lv_d     = lv_q;
      last_d   = last_q;
      err_d    = err_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               nc_d     = node_count_i;
               lim_d    = edge_limit_i;
               comp_d   = node_count_i;
               ec_d     = '0;
               merges_d = '0;
               lu_d     = '0;
               lv_d     = '0;
               err_d    = 1'b0;
               // A graph of 0 or 1 nodes is already fully connected.
               state_d  = (node_count_i <= CW'(1)) ? S_DONE : S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            if (bus.edge_valid) begin
               u_d    = bus.edge_u;
               v_d    = bus.edge_v;
               last_d = bus.edge_last;
               if (ec_q != '1) ec_d = ec_q + LW'(1);
               if (CW'(bus.edge_u) >= nc_q || CW'(bus.edge_v) >= nc_q) begin
                  err_d   = 1'b1;
                  state_d = S_CHECK;
               end else if (bus.edge_u == bus.edge_v) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_FIND_U;
               end
            end
         end
         S_FIND_U: if (bus.find_req_ready) state_d = S_WAIT_U;
         S_WAIT_U: begin
            if (bus.find_rsp_valid) begin
               ru_d    = bus.find_rsp_root;
               state_d = S_FIND_V;
            end
         end
         S_FIND_V: if (bus.find_req_ready) state_d = S_WAIT_V;
         S_WAIT_V: begin
            if (bus.find_rsp_valid) begin
               rv_d    = bus.find_rsp_root;
               state_d = (bus.find_rsp_root == ru_q) ? S_CHECK : S_LINK;
            end
         end
         S_LINK: begin
            if (bus.link_ready) begin
               if (comp_q > CW'(1)) comp_d = comp_q - CW'(1);
               merges_d = merges_q + CW'(1);
               lu_d     = u_q;
               lv_d     = v_q;
               state_d  = S_CHECK;
            end
         end
         S_CHECK: begin
            if (comp_q == CW'(1) || (lim_q != '0 && ec_q == lim_q) || last_q)
               state_d = S_DONE;
            else
               state_d = S_ACCEPT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Smaller root becomes the parent, so every set's root is its smallest member.
   assign ru_lt              = (ru_q < rv_q);
   assign bus.edge_ready     = (state_q == S_ACCEPT);
   assign bus.find_req_valid = (state_q == S_FIND_U) || (state_q == S_FIND_V);
   assign bus.find_req_idx   = (state_q == S_FIND_U) ? u_q :
                               (state_q == S_FIND_V) ? v_q : '0;
   assign bus.link_valid     = (state_q == S_LINK);
   assign bus.link_parent    = (state_q != S_LINK) ? '0 : (ru_lt ? ru_q : rv_q);
   assign bus.link_child     = (state_q != S_LINK) ? '0 : (ru_lt ? rv_q : ru_q);

   assign busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o           = (state_q == S_DONE);
   assign error_o          = err_q;
   assign components_o     = comp_q;
   assign edges_consumed_o = ec_q;
   assign merges_o         = merges_q;
   assign last_u_o         = lu_q;
   assign last_v_o         = lv_q;
endmodule

// File: tb/tb_uf_edge_scheduler.sv
// Bench for uf_edge_scheduler: table vectors, random runs against a set-label
// connectivity model, stall stability and mid-run reset sequences.
module tb_uf_edge_scheduler;
   localparam int MAXN = 2000;
   localparam int IW   = $clog2(MAXN);
   localparam int CW   = $clog2(MAXN + 1);
   localparam int LW   = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [CW-1:0] node_count_i;
   logic [LW-1:0] edge_limit_i;
   logic          busy_o, done_o, error_o;
   logic [CW-1:0] components_o, merges_o;
   logic [LW-1:0] edges_consumed_o;
   logic [IW-1:0] last_u_o, last_v_o;

   uf_edge_scheduler_if #(.IW(IW)) bus ();

   uf_edge_scheduler #(.MAX_NODE_COUNT(MAXN), .LIMIT_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .node_count_i(node_count_i),
      .edge_limit_i(edge_limit_i), .bus(bus), .busy_o(busy_o), .done_o(done_o),
      .error_o(error_o), .components_o(components_o), .edges_consumed_o(edges_consumed_o),
      .merges_o(merges_o), .last_u_o(last_u_o), .last_v_o(last_v_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int nc, lim, n, fs, ls;
      int eu[8];
      int ev[8];
      int comp, mer, ec, lu, lv, err;
   } vec_t;

   int total = 0, bad = 0;
   int par[2048];
   int q_u[$], q_v[$];
   int ptr, hs, finds, fcnt, lcnt, fstall, lstall, viol, rsp_root, fheld_idx, lheld_c, lheld_p;
   bit rsp_pend, fheld, lheld;
   int act_lc[$], act_lp[$];
   int m_comp, m_mer, m_ec, m_lu, m_lv, m_err, m_finds;
   int m_lc[$], m_lp[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int root_of(input int idx);
      int r = idx;
      while (par[r] != r) r = par[r];
      return r;
   endfunction

   // Engine/sorter behaviour: observe handshakes before the edge, drive after it.
   task automatic tick();
      if (bus.edge_valid && bus.edge_ready) begin hs++; ptr++; end
      if (bus.find_req_valid) begin
         if (fheld && int'(bus.find_req_idx) != fheld_idx) viol++;
         if (bus.find_req_ready) begin
            fheld = 0; finds++; rsp_root = root_of(int'(bus.find_req_idx)); rsp_pend = 1; fcnt = fstall;
         end else begin
            fheld = 1; fheld_idx = int'(bus.find_req_idx); if (fcnt > 0) fcnt--;
         end
      end
      if (bus.link_valid) begin
         if (lheld && (int'(bus.link_child) != lheld_c || int'(bus.link_parent) != lheld_p)) viol++;
         if (bus.link_ready) begin
            lheld = 0; par[int'(bus.link_child)] = int'(bus.link_parent);
            act_lc.push_back(int'(bus.link_child)); act_lp.push_back(int'(bus.link_parent));
            lcnt = lstall;
         end else begin
            lheld = 1; lheld_c = int'(bus.link_child); lheld_p = int'(bus.link_parent);
            if (lcnt > 0) lcnt--;
         end
      end
      @(posedge clk);
      #1;
      bus.edge_valid     = (ptr < q_u.size());
      bus.edge_u         = (ptr < q_u.size()) ? IW'(q_u[ptr]) : '0;
      bus.edge_v         = (ptr < q_v.size()) ? IW'(q_v[ptr]) : '0;
      bus.edge_last      = (ptr == q_u.size() - 1);
      bus.find_req_ready = (fcnt == 0);
      bus.link_ready     = (lcnt == 0);
      bus.find_rsp_valid = rsp_pend;
      bus.find_rsp_root  = IW'(rsp_root);
      rsp_pend = 0;
      #1;
   endtask

   // Reference: each set is labelled by its smallest member, which is where a
   // smaller-root-wins link policy must leave the root.
   task automatic model(input int nc, input int lim);
      int lab[2048];
      int a, b, lo, hi;
      m_comp = nc; m_mer = 0; m_ec = 0; m_lu = 0; m_lv = 0; m_err = 0; m_finds = 0;
      m_lc.delete(); m_lp.delete();
      for (int i = 0; i < 2048; i++) lab[i] = i;
      if (nc > 1) begin
         for (int k = 0; k < q_u.size(); k++) begin
            m_ec++;
            if (q_u[k] >= nc || q_v[k] >= nc) m_err = 1;
            else if (q_u[k] != q_v[k]) begin
               m_finds += 2;
               a = lab[q_u[k]]; b = lab[q_v[k]];
               if (a != b) begin
                  lo = (a < b) ? a : b; hi = (a < b) ? b : a;
                  for (int j = 0; j < nc; j++) if (lab[j] == hi) lab[j] = lo;
                  m_comp--; m_mer++; m_lu = q_u[k]; m_lv = q_v[k];
                  m_lc.push_back(hi); m_lp.push_back(lo);
               end
            end
            if (m_comp == 1 || (lim != 0 && m_ec == lim) || k == q_u.size() - 1) break;
         end
      end
   endtask

   task automatic run(input int nc, input int lim, input string tag);
      int cyc = 0;
      for (int i = 0; i < 2048; i++) par[i] = i;
      ptr = 0; hs = 0; finds = 0; viol = 0; fheld = 0; lheld = 0; rsp_pend = 0;
      fcnt = fstall; lcnt = lstall;
      act_lc.delete(); act_lp.delete();
      start_i = 1'b1; node_count_i = CW'(nc); edge_limit_i = LW'(lim);
      tick();
      start_i = 1'b0;
      if (nc > 1) chk({tag, "/busy"}, int'(busy_o), 1);
      while (!done_o && cyc < 3000) begin tick(); cyc++; end
      chk({tag, "/done"}, int'(done_o), 1);
   endtask

   task automatic check_model(input string tag);
      int h0;
      chk({tag, "/m_comp"}, int'(components_o), m_comp);
      chk({tag, "/m_merges"}, int'(merges_o), m_mer);
      chk({tag, "/m_consumed"}, int'(edges_consumed_o), m_ec);
      chk({tag, "/m_handshakes"}, hs, m_ec);
      chk({tag, "/m_last_u"}, int'(last_u_o), m_lu);
      chk({tag, "/m_last_v"}, int'(last_v_o), m_lv);
      chk({tag, "/m_error"}, int'(error_o), m_err);
      chk({tag, "/m_finds"}, finds, m_finds);
      chk({tag, "/m_links"}, act_lc.size(), m_lc.size());
      for (int i = 0; i < act_lc.size() && i < m_lc.size(); i++) begin
         chk({tag, "/link_child"}, act_lc[i], m_lc[i]);
         chk({tag, "/link_parent"}, act_lp[i], m_lp[i]);
      end
      chk({tag, "/stable"}, viol, 0);
      h0 = hs;
      for (int i = 0; i < 4; i++) begin
         if (bus.edge_ready) viol++;
         tick();
      end
      chk({tag, "/post_done_ready"}, viol, 0);
      chk({tag, "/post_done_hs"}, hs, h0);
   endtask

   initial begin
      vec_t tbl[9];
      int nc, lim, ne;
      tbl[0] = '{4, 0, 3, 0, 0, '{0, 2, 1, 0, 0, 0, 0, 0}, '{1, 3, 2, 0, 0, 0, 0, 0}, 1, 3, 3, 1, 2, 0};
      tbl[1] = '{4, 0, 4, 0, 0, '{0, 1, 2, 3, 0, 0, 0, 0}, '{1, 0, 2, 3, 0, 0, 0, 0}, 3, 1, 4, 0, 1, 0};
      tbl[2] = '{10, 2, 5, 0, 0, '{0, 2, 4, 6, 8, 0, 0, 0}, '{1, 3, 5, 7, 9, 0, 0, 0}, 8, 2, 2, 2, 3, 0};
      tbl[3] = '{4, 0, 2, 5, 3, '{0, 2, 0, 0, 0, 0, 0, 0}, '{1, 3, 0, 0, 0, 0, 0, 0}, 2, 2, 2, 2, 3, 0};
      tbl[4] = '{4, 0, 1, 0, 0, '{7, 0, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 0}, 4, 0, 1, 0, 0, 1};
      tbl[5] = '{4, 0, 3, 1, 1, '{3, 0, 1, 0, 0, 0, 0, 0}, '{2, 7, 0, 0, 0, 0, 0, 0}, 2, 2, 3, 1, 0, 1};
      tbl[6] = '{1, 0, 1, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 1, 0, 0, 0, 0, 0};
      tbl[7] = '{0, 0, 0, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 0, 0, 0, 0, 0};
      tbl[8] = '{5, 3, 4, 0, 2, '{1, 2, 3, 4, 0, 0, 0, 0}, '{0, 1, 2, 3, 0, 0, 0, 0}, 2, 3, 3, 3, 2, 0};

      rst = 1'b1; start_i = 1'b0; node_count_i = '0; edge_limit_i = '0;
      bus.edge_valid = 1'b0; bus.edge_u = '0; bus.edge_v = '0; bus.edge_last = 1'b0;
      bus.find_req_ready = 1'b0; bus.find_rsp_valid = 1'b0; bus.find_rsp_root = '0;
      bus.link_ready = 1'b0;
      fstall = 0; lstall = 0; ptr = 0; fcnt = 0; lcnt = 0; rsp_pend = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset/busy", int'(busy_o), 0);
      chk("reset/done", int'(done_o), 0);
      chk("reset/comp", int'(components_o), 0);
      chk("reset/edge_ready", int'(bus.edge_ready), 0);
      rst = 1'b0;
      tick();

      for (int t = 0; t < 9; t++) begin
         string tag;
         tag = $sformatf("vec%0d", t);
         q_u.delete(); q_v.delete();
         for (int k = 0; k < tbl[t].n; k++) begin q_u.push_back(tbl[t].eu[k]); q_v.push_back(tbl[t].ev[k]); end
         fstall = tbl[t].fs; lstall = tbl[t].ls;
         model(tbl[t].nc, tbl[t].lim);
         run(tbl[t].nc, tbl[t].lim, tag);
         chk({tag, "/comp"}, int'(components_o), tbl[t].comp);
         chk({tag, "/merges"}, int'(merges_o), tbl[t].mer);
         chk({tag, "/consumed"}, int'(edges_consumed_o), tbl[t].ec);
         chk({tag, "/last_u"}, int'(last_u_o), tbl[t].lu);
         chk({tag, "/last_v"}, int'(last_v_o), tbl[t].lv);
         chk({tag, "/error"}, int'(error_o), tbl[t].err);
         check_model(tag);
      end

      for (int r = 0; r < 25; r++) begin
         string tag;
         tag = $sformatf("rand%0d", r);
         nc  = $urandom_range(2, 12);
         lim = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 8);
         ne  = $urandom_range(1, 10);
         q_u.delete(); q_v.delete();
         for (int k = 0; k < ne; k++) begin
            q_u.push_back($urandom_range(0, nc + 1));
            q_v.push_back($urandom_range(0, nc + 1));
         end
         fstall = $urandom_range(0, 3); lstall = $urandom_range(0, 3);
         model(nc, lim);
         run(nc, lim, tag);
         check_model(tag);
      end

      // Reset landing in WAIT_V must clear everything; a fresh run then works.
      q_u = '{0, 2}; q_v = '{1, 3};
      fstall = 0; lstall = 0;
      for (int i = 0; i < 2048; i++) par[i] = i;
      ptr = 0; hs = 0; finds = 0; fcnt = 0; lcnt = 0; fheld = 0; lheld = 0;
      start_i = 1'b1; node_count_i = CW'(4); edge_limit_i = '0;
      tick();
      start_i = 1'b0;
      for (int c = 0; c < 50 && finds < 2; c++) tick();
      chk("rstmid/reached_wait_v", finds, 2);
      rst = 1'b1;
      rsp_pend = 0; bus.find_rsp_valid = 1'b0; bus.edge_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("rstmid/busy", int'(busy_o), 0);
      chk("rstmid/done", int'(done_o), 0);
      chk("rstmid/comp", int'(components_o), 0);
      chk("rstmid/consumed", int'(edges_consumed_o), 0);
      chk("rstmid/find_valid", int'(bus.find_req_valid), 0);
      chk("rstmid/find_idx", int'(bus.find_req_idx), 0);
      chk("rstmid/link_valid", int'(bus.link_valid), 0);
      chk("rstmid/edge_ready", int'(bus.edge_ready), 0);
      rst = 1'b0;
      q_u = '{0, 2, 1}; q_v = '{1, 3, 2};
      tick();
      model(4, 0);
      run(4, 0, "rstmid/rerun");
      chk("rstmid/rerun_comp", int'(components_o), 1);
      check_model("rstmid/rerun");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
